pipelining: RTL and testbench

- 3-stage pipelined arithmetic datapath computing F = ((A + B) + (C - D)) * D.
- Accepts a new operand set on every rising clock edge and produces one result per cycle after a fixed 3-cycle latency.
- Used as the reference pipelined-datapath block; no handshake, fully streaming.

---
 rtl/pipelining.sv | 55 +++++
 tb/tb_pipelining.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipelining.sv
// Three-stage streaming datapath: F = ((A + B) + (C - D)) * D, modulo 2^WIDTH.
// One operand set is accepted per clock. Its result reaches F three edges
// after it is sampled. D travels through the pipeline with its own operand set.
module pipelining #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] F
);

  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] d2;

  // Stage 1: partial sum and wrapping difference; capture D for the multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0;
      x2 <= '0;
      d1 <= '0;
    end else begin
      x1 <= WIDTH'(A + B);
      x2 <= WIDTH'(C - D);
      d1 <= D;
    end
  end

  // Stage 2: combine the partial results; D moves one stage further
  always_ff @(posedge clk) begin
    if (rst) begin
      x3 <= '0;
      d2 <= '0;
    end else begin
      x3 <= WIDTH'(x1 + x2);
      d2 <= d1;
    end
  end

  // Stage 3: multiply by the D of the same operand set and keep the low WIDTH bits
  always_ff @(posedge clk) begin
    if (rst) begin
      F <= '0;
    end else begin
      F <= WIDTH'(x3 * d2);
    end
  end

endmodule

// File: tb/tb_pipelining.sv
// Directed and random checks for the pipelining datapath (WIDTH = 10).
module tb_pipelining;

  localparam int unsigned WIDTH = 10;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] F;

  int checks;
  int failures;

  logic [WIDTH-1:0] exp_q[$];

  pipelining #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .F  (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count the result
  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: F=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Change the inputs on the falling edge. They are sampled on the next rising edge.
  task automatic tick(input logic r, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    C   = c;
    D   = d;
  endtask

  // Reference result, computed step by step with explicit 10-bit wrap
  function automatic logic [WIDTH-1:0] ref_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] u;
    s = WIDTH'(a + b);
    t = WIDTH'(c - d);
    u = WIDTH'(s + t);
    return WIDTH'(u * d);
  endfunction

  // Stream one operand set with its expected result.
  // After each tick, F holds the result of the set driven three ticks earlier.
  task automatic stream(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    tick(1'b0, a, b, c, d);
    exp_q.push_back(exp);
    if (exp_q.size() == 4) check(tag, F, exp_q.pop_front());
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    A = 10'd0; B = 10'd0; C = 10'd0; D = 10'd0;

    // Two cycles of reset with arbitrary operands on the inputs
    tick(1'b1, 10'd123, 10'd456, 10'd789, 10'd321);
    tick(1'b1, 10'd999, 10'd17,  10'd3,   10'd512);
    check("reset_hold", F, 10'd0);

    // First operands after reset: F stays 0 for two more ticks, then shows 75
    tick(1'b0, 10'd10, 10'd12, 10'd6, 10'd3);
    tick(1'b0, 10'd0,  10'd0,  10'd0, 10'd0);
    check("post_reset_0", F, 10'd0);
    tick(1'b0, 10'd0,  10'd0,  10'd0, 10'd0);
    check("post_reset_1", F, 10'd0);
    tick(1'b0, 10'd0,  10'd0,  10'd0, 10'd0);
    check("single_75", F, 10'd75);
    tick(1'b0, 10'd0,  10'd0,  10'd0, 10'd0);
    check("idle_zero", F, 10'd0);

    // Back-to-back directed vectors with hand-computed results
    exp_q.delete();
    stream("stream_a",   10'd10,   10'd12,   10'd6,   10'd3,    10'd75);
    stream("stream_b",   10'd10,   10'd10,   10'd5,   10'd3,    10'd66);
    stream("stream_c",   10'd20,   10'd1,    10'd1,   10'd4,    10'd72);
    stream("ovf_add",    10'd1000, 10'd1000, 10'd0,   10'd0,    10'd0);
    stream("d_zero",     10'd100,  10'd0,    10'd0,   10'd0,    10'd0);
    stream("mul_trunc",  10'd500,  10'd0,    10'd20,  10'd10,   10'd1004);
    stream("mixed",      10'd7,    10'd9,    10'd300, 10'd5,    10'd531);
    stream("d_max",      10'd0,    10'd0,    10'd0,   10'd1023, 10'd1023);
    stream("flush_0",    10'd0,    10'd0,    10'd0,   10'd0,    10'd0);
    stream("flush_1",    10'd0,    10'd0,    10'd0,   10'd0,    10'd0);
    stream("flush_2",    10'd0,    10'd0,    10'd0,   10'd0,    10'd0);

    // Reset in the middle of a stream discards everything in flight
    tick(1'b0, 10'd10, 10'd12, 10'd6,  10'd3);
    tick(1'b0, 10'd500, 10'd0, 10'd20, 10'd10);
    tick(1'b1, 10'd20, 10'd1,  10'd1,  10'd4);
    tick(1'b0, 10'd1,  10'd2,  10'd3,  10'd1);
    check("mid_rst_0", F, 10'd0);
    tick(1'b0, 10'd2,  10'd2,  10'd9,  10'd3);
    check("mid_rst_1", F, 10'd0);
    tick(1'b0, 10'd0,  10'd0,  10'd0,  10'd0);
    check("mid_rst_2", F, 10'd0);
    tick(1'b0, 10'd0,  10'd0,  10'd0,  10'd0);
    check("mid_rst_new_a", F, 10'd5);
    tick(1'b0, 10'd0,  10'd0,  10'd0,  10'd0);
    check("mid_rst_new_b", F, 10'd30);

    // Random streaming against the reference function
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra, rb, rc, rd;
      ra = WIDTH'($urandom_range(0, 1023));
      rb = WIDTH'($urandom_range(0, 1023));
      rc = WIDTH'($urandom_range(0, 1023));
      rd = WIDTH'($urandom_range(0, 1023));
      stream("random", ra, rb, rc, rd, ref_f(ra, rb, rc, rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
